// File: rtl/seq_addsub_pkg.sv
// Shared types and helpers for the digit-serial adder/subtractor.
package seq_addsub_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBusy = 2'd1,
    StDone = 2'd2
  } state_e;

  // Digit counter width; a single-digit configuration still needs one bit.
  function automatic int unsigned cnt_width(input int unsigned ndig);
    return (ndig > 1) ? $clog2(ndig) : 1;
  endfunction

endpackage

// File: rtl/seq_addsub_unit_digit_adder.sv
// Combinational DIGIT-bit ripple adder slice; also exposes the carry into its top bit.
module digit_adder #(
  parameter int unsigned DIGIT = 4
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             ci,
  output logic [DIGIT-1:0] s,
  output logic             co,
  output logic             c_msb
);

  logic [DIGIT:0] c;

  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = ci;
    for (int i = 0; i < DIGIT; i++) begin
      s[i]   = x[i] ^ y[i] ^ c[i];
      c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
    end
  end

  assign co    = c[DIGIT];
  assign c_msb = c[DIGIT-1];

endmodule

// File: rtl/seq_addsub_unit.sv
// Digit-serial WIDTH-bit adder/subtractor with valid/ready on input and output.
module seq_addsub_unit
  import seq_addsub_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned NDIG = WIDTH / ((DIGIT == 0) ? 1 : DIGIT);
  localparam int unsigned CW   = cnt_width(NDIG);

  if ((DIGIT == 0) || ((WIDTH % ((DIGIT == 0) ? 1 : DIGIT)) != 0)) begin : g_bad_digit
    $error("seq_addsub_unit: DIGIT must be non-zero and divide WIDTH");
  end

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d, sum_shift;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d;
  logic [DIGIT-1:0] slice_s;
  logic             slice_co, slice_cmsb;

  digit_adder #(
    .DIGIT (DIGIT)
  ) u_slice (
    .x     (a_q[DIGIT-1:0]),
    .y     (b_q[DIGIT-1:0]),
    .ci    (carry_q),
    .s     (slice_s),
    .co    (slice_co),
    .c_msb (slice_cmsb)
  );

  // New digits enter at the MSB end so the LS digit lands at bit 0 after NDIG shifts.
  if (DIGIT == WIDTH) begin : g_one_digit
    assign sum_shift = slice_s;
  end else begin : g_multi_digit
    assign sum_shift = {slice_s, sum_q[WIDTH-1:DIGIT]};
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = cin ^ sub;
          cnt_d   = '0;
          state_d = StBusy;
        end
      end
      StBusy: begin
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        carry_d = slice_co;
        sum_d   = sum_shift;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(NDIG - 1)) begin
          cout_d  = slice_co;
          ovf_d   = slice_cmsb ^ slice_co;
          state_d = StDone;
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_seq_addsub_unit.sv
// Bench: 16/4 and 8/8 instances checked against an arithmetic reference model.
module tb_seq_addsub_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        in_valid = 1'b0, in_ready, cin = 1'b0, sub = 1'b0;
  logic        out_valid, out_ready = 1'b0, cout, ovf;
  logic [15:0] a = '0, b = '0, sum;

  logic        e_in_valid = 1'b0, e_in_ready, e_cin = 1'b0, e_sub = 1'b0;
  logic        e_out_valid, e_out_ready = 1'b0, e_cout, e_ovf;
  logic [7:0]  e_a = '0, e_b = '0, e_sum;

  int errors = 0;
  int checks = 0;

  seq_addsub_unit #(.WIDTH(16), .DIGIT(4)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .cin(cin), .sub(sub), .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
    .cout(cout), .ovf(ovf)
  );

  seq_addsub_unit #(.WIDTH(8), .DIGIT(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(e_in_valid), .in_ready(e_in_ready), .a(e_a),
    .b(e_b), .cin(e_cin), .sub(e_sub), .out_valid(e_out_valid), .out_ready(e_out_ready),
    .sum(e_sum), .cout(e_cout), .ovf(e_ovf)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: full-precision integer add of A, (B or ~B) and the effective carry.
  function automatic void model(input int w, input logic [15:0] x, input logic [15:0] y,
                                input logic ci, input logic sb, output logic [15:0] s,
                                output logic co, output logic ov);
    longint m, half, yy, c, full, sx, sy, st;
    m    = (longint'(1) << w) - 1;
    half = longint'(1) << (w - 1);
    yy   = sb ? (~longint'(y)) & m : longint'(y) & m;
    c    = (ci ^ sb) ? 1 : 0;
    full = (longint'(x) & m) + yy + c;
    s    = 16'(full & m);
    co   = ((full >> w) & 1) != 0;
    sx   = ((longint'(x) & m) >= half) ? (longint'(x) & m) - (m + 1) : (longint'(x) & m);
    sy   = (yy >= half) ? yy - (m + 1) : yy;
    st   = sx + sy + c;
    ov   = (st >= half) || (st < -half);
  endfunction

  task automatic wait_done16(output int n);
    n = 0;
    while (!out_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic check_result16(input string tag, input logic [15:0] x, input logic [15:0] y,
                                input logic ci, input logic sb);
    logic [15:0] es;
    logic ec, eo;
    model(16, x, y, ci, sb, es, ec, eo);
    chk({tag, " sum"}, 32'(sum), 32'(es));
    chk({tag, " cout"}, 32'(cout), 32'(ec));
    chk({tag, " ovf"}, 32'(ovf), 32'(eo));
  endtask

  task automatic release16(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, " out_valid after handshake"}, 32'(out_valid), 32'd0);
    chk({tag, " in_ready after handshake"}, 32'(in_ready), 32'd1);
  endtask

  task automatic op16(input string tag, input logic [15:0] x, input logic [15:0] y,
                      input logic ci, input logic sb);
    int n;
    in_valid = 1'b1; a = x; b = y; cin = ci; sub = sb;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); sub = 1'($urandom);
    wait_done16(n);
    chk({tag, " latency"}, 32'(n), 32'd4);
    check_result16(tag, x, y, ci, sb);
    release16(tag);
  endtask

  task automatic op8(input string tag, input logic [7:0] x, input logic [7:0] y,
                     input logic ci, input logic sb);
    logic [15:0] es;
    logic ec, eo;
    int n;
    model(8, {8'h00, x}, {8'h00, y}, ci, sb, es, ec, eo);
    e_in_valid = 1'b1; e_a = x; e_b = y; e_cin = ci; e_sub = sb;
    @(posedge clk); #1;
    e_in_valid = 1'b0;
    e_a = 8'($urandom); e_b = 8'($urandom);
    n = 0;
    while (!e_out_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, " latency8"}, 32'(n), 32'd1);
    chk({tag, " sum8"}, 32'(e_sum), 32'(es[7:0]));
    chk({tag, " cout8"}, 32'(e_cout), 32'(ec));
    chk({tag, " ovf8"}, 32'(e_ovf), 32'(eo));
    e_out_ready = 1'b1;
    @(posedge clk); #1;
    e_out_ready = 1'b0;
    chk({tag, " out_valid8 after handshake"}, 32'(e_out_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] es, bx, by;
    logic ec, eo;
    int n;

    // Reset
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("reset in_ready", 32'(in_ready), 32'd1);
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset sum", 32'(sum), 32'h0);
    chk("reset cout", 32'(cout), 32'd0);
    chk("reset ovf", 32'(ovf), 32'd0);
    chk("reset in_ready8", 32'(e_in_ready), 32'd1);
    chk("reset out_valid8", 32'(e_out_valid), 32'd0);

    // Directed cases, with spot-checks of the model against hand-derived constants
    op16("add", 16'h000F, 16'h0001, 1'b0, 1'b0);
    chk("add sum const", 32'(sum), 32'h0010);
    op16("add carry", 16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
    op16("add ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0);
    chk("add ovf sum const", 32'(sum), 32'h8000);
    op16("sub neg", 16'h0005, 16'h000A, 1'b0, 1'b1);
    chk("sub neg sum const", 32'(sum), 32'hFFFB);
    op16("sub ovf", 16'h8000, 16'h0001, 1'b0, 1'b1);
    chk("sub ovf sum const", 32'(sum), 32'h7FFF);
    chk("sub ovf cout const", 32'(cout), 32'd1);
    chk("sub ovf ovf const", 32'(ovf), 32'd1);

    // Backpressure: result held while new operands are presented
    in_valid = 1'b1; a = 16'h1111; b = 16'h2222; cin = 1'b0; sub = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_done16(n);
    chk("bp latency", 32'(n), 32'd4);
    model(16, 16'h1111, 16'h2222, 1'b0, 1'b0, es, ec, eo);
    bx = 16'($urandom); by = 16'($urandom);
    in_valid = 1'b1; a = bx; b = by; cin = 1'b1; sub = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp out_valid held", 32'(out_valid), 32'd1);
      chk("bp in_ready low", 32'(in_ready), 32'd0);
      chk("bp sum stable", 32'(sum), 32'(es));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp out_valid after handshake", 32'(out_valid), 32'd0);
    chk("bp in_ready after handshake", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp accepted", 32'(in_ready), 32'd0);
    wait_done16(n);
    chk("bp next latency", 32'(n), 32'd4);
    check_result16("bp next", bx, by, 1'b1, 1'b1);
    release16("bp next");

    // Reset while BUSY at digit 2
    in_valid = 1'b1; a = 16'hABCD; b = 16'h1357; cin = 1'b1; sub = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    chk("midreset in_ready", 32'(in_ready), 32'd1);
    chk("midreset out_valid", 32'(out_valid), 32'd0);
    chk("midreset sum", 32'(sum), 32'h0);
    rst_n = 1'b1;
    op16("after reset", 16'h1234, 16'h4321, 1'b0, 1'b0);
    chk("after reset sum const", 32'(sum), 32'h5555);

    // Single-digit configuration
    op8("w8 add", 8'h0F, 8'h01, 1'b0, 1'b0);
    op8("w8 carry", 8'hFF, 8'hFF, 1'b1, 1'b0);
    op8("w8 ovf", 8'h7F, 8'h01, 1'b0, 1'b0);
    op8("w8 sub", 8'h80, 8'h01, 1'b0, 1'b1);

    // Randomized operations on both instances
    for (int i = 0; i < 20; i++) begin
      op16("rand16", 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
      op8("rand8", 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
